// File: rtl/p1_pkg.sv
// p1_pkg -- shared definitions for the p1 truth-table BIST.
//   state_t : 3-bit FSM state encoding used by p1_bist
//   NUM_VEC : number of input vectors swept (all combinations of a,b,c,d)
//   VEC_W   : width of the vector index {a,b,c,d}
package p1_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/p1_settle_cnt.sv
// p1_settle_cnt -- loadable down-counter that times how long a vector is held
// before the response is sampled.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count to 0)
//   load     : load load_val on the next edge
//   load_val : value loaded (hold length minus one)
//   cnt      : current count
//   expire   : high while the count has reached 0
module p1_settle_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] cnt,
    output logic       expire
);

    // Counts down freely and parks at zero; the FSM only looks at expire
    // while it is in APPLY, right after a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expire = (cnt == 4'd0);

endmodule

// File: rtl/p1_bist.sv
// p1_bist -- sweeps all 16 input vectors of the 4-input p1 device, holds each
// enabled vector for SETTLE cycles, samples the response and compares it with
// a latched golden truth table.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start               : one-cycle sweep request, honoured only when idle
//   expected[15:0]      : golden truth table (bit i = expected q for vector i)
//   vec_mask[15:0]      : bit i = 1 checks vector i, 0 skips it
//   q_in                : response of the device under test
//   a, b, c, d          : registered stimulus, {a,b,c,d} = current vector index
//   busy                : high whenever not idle
//   done                : one-cycle pulse at the end of a sweep
//   pass                : no enabled vector mismatched (valid from done on)
//   err_cnt[4:0]        : number of mismatching enabled vectors
//   fail_idx[3:0]       : first mismatching vector index, 0 if none
//   resp[15:0]          : captured responses, skipped vectors read 0
module p1_bist
    import p1_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic [15:0] vec_mask,
    input  logic        q_in,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  fail_idx,
    output logic [15:0] resp
);

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_IDX  = VEC_W'(NUM_VEC - 1);

    state_t             state;
    state_t             state_nxt;
    logic [VEC_W-1:0]   idx;
    logic [VEC_W-1:0]   vec;
    logic [NUM_VEC-1:0] exp_lat;
    logic [NUM_VEC-1:0] mask_lat;
    logic               settle_load;
    logic               settle_expire;
    logic [3:0]         settle_cnt;

    p1_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LD),
        .cnt      (settle_cnt),
        .expire   (settle_expire)
    );

    always_comb begin
        state_nxt   = state;
        settle_load = 1'b0;
        busy        = (state != ST_IDLE);
        done        = (state == ST_DONE);
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_APPLY;
            ST_APPLY: begin
                // Skipped vectors spend a single cycle here, with no sampling.
                if (!mask_lat[idx])     state_nxt = ST_ADVANCE;
                else if (settle_expire) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE:  state_nxt = ST_ADVANCE;
            ST_ADVANCE: state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_APPLY;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // Arm the hold timer on every entry into APPLY so it reads SETTLE-1
        // in the first APPLY cycle and expires after SETTLE cycles.
        if (state_nxt == ST_APPLY && state != ST_APPLY) settle_load = 1'b1;
    end

    // Golden table and mask are snapshots taken when a sweep is accepted.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            exp_lat  <= expected;
            mask_lat <= vec_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            idx      <= '0;
            vec      <= '0;
            pass     <= 1'b0;
            err_cnt  <= 5'd0;
            fail_idx <= 4'd0;
            resp     <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        vec      <= '0;
                        pass     <= 1'b0;
                        err_cnt  <= 5'd0;
                        fail_idx <= 4'd0;
                        resp     <= 16'd0;
                    end
                end
                ST_SAMPLE: begin
                    resp[idx] <= q_in;
                    if (q_in != exp_lat[idx]) begin
                        err_cnt <= err_cnt + 5'd1;
                        // err_cnt still zero means this is the first mismatch.
                        if (err_cnt == 5'd0) fail_idx <= idx;
                    end
                end
                ST_ADVANCE: begin
                    if (idx == LAST_IDX) begin
                        vec  <= '0;
                        pass <= (err_cnt == 5'd0);
                    end else begin
                        idx <= idx + 1'b1;
                        vec <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c, d} = vec;

endmodule

// File: tb/tb_p1_bist.sv
// tb_p1_bist -- self-checking bench for p1_bist. A behavioural p1 device
// (truth table indexed by {a,b,c,d}) answers the stimulus; expected results
// come from a model working on whole 16-bit tables with plain arithmetic.
module tb_p1_bist;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] expected;
    logic [15:0] vec_mask;
    logic        q_in;
    logic        a, b, c, d;
    logic        busy, done, pass;
    logic [4:0]  err_cnt;
    logic [3:0]  fail_idx;
    logic [15:0] resp;

    logic [15:0] dev_tt = 16'd0;
    logic [15:0] p1_tt;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Combinational device under test driven by the BIST stimulus.
    assign q_in = dev_tt[{a, b, c, d}];

    p1_bist #(.SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .expected (expected),
        .vec_mask (vec_mask),
        .q_in     (q_in),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_idx (fail_idx),
        .resp     (resp)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference p1 function: q = (a & b) | (c ^ d).
    function automatic logic [15:0] build_p1();
        logic [15:0] tt;
        logic [3:0]  v;
        tt = '0;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            tt[i] = (v[3] & v[2]) | (v[1] ^ v[0]);
        end
        return tt;
    endfunction

    function automatic logic [3:0] first_set(input logic [15:0] x);
        for (int i = 0; i < 16; i++) if (x[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, ":abcd"},     {28'd0, a, b, c, d}, 32'd0);
        check({tag, ":busy"},     busy,     0);
        check({tag, ":done"},     done,     0);
        check({tag, ":pass"},     pass,     0);
        check({tag, ":err_cnt"},  err_cnt,  0);
        check({tag, ":fail_idx"}, fail_idx, 0);
        check({tag, ":resp"},     resp,     0);
    endtask

    // One complete sweep: stimulus, per-cycle vector sequence tracking,
    // and result checks against the model, followed by a hold check in idle.
    task automatic sweep(input string name, input logic [15:0] e, input logic [15:0] m,
                         input logic [15:0] dv, input bit spam);
        logic [3:0]  seq[$];
        logic [15:0] bad;
        int          k, lat, vec_bad, extra, t;
        seq = {};
        for (int i = 0; i < 16; i++)
            repeat (m[i] ? SETTLE + 2 : 2) seq.push_back(4'(i));
        seq.push_back(4'd0);
        k   = seq.size() - 1;
        bad = (e ^ dv) & m;

        dev_tt   = dv;
        expected = e;
        vec_mask = m;
        start    = 1'b1;
        @(posedge clk); #1;
        if (!spam) start = 1'b0;

        lat     = -1;
        vec_bad = 0;
        for (t = 0; t <= k + 20; t++) begin
            if (t < seq.size() && {a, b, c, d} !== seq[t]) vec_bad++;
            if (done === 1'b1) begin
                lat = t;
                break;
            end
            // Inputs wander mid-sweep; only the latched copies may matter.
            expected = 16'($urandom);
            vec_mask = 16'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;

        check({name, ":latency"},  lat, k);
        check({name, ":vec_seq"},  vec_bad, 0);
        check({name, ":busy"},     busy, 1);
        check({name, ":pass"},     pass, (bad == 16'd0));
        check({name, ":err_cnt"},  err_cnt, $countones(bad));
        check({name, ":fail_idx"}, fail_idx, first_set(bad));
        check({name, ":resp"},     resp, dv & m);

        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        check({name, ":extra_done"}, extra, 0);
        check({name, ":idle_busy"},  busy, 0);
        check({name, ":idle_abcd"},  {28'd0, a, b, c, d}, 32'd0);
        check({name, ":hold_pass"},  pass, (bad == 16'd0));
        check({name, ":hold_err"},   err_cnt, $countones(bad));
        check({name, ":hold_resp"},  resp, dv & m);
    endtask

    initial begin
        int dones;
        rst      = 1'b1;
        start    = 1'b0;
        expected = 16'd0;
        vec_mask = 16'd0;
        p1_tt    = build_p1();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        sweep("full",      p1_tt,            16'hFFFF, p1_tt, 1'b0);
        sweep("mask3f3f",  p1_tt,            16'h3F3F, p1_tt, 1'b0);
        sweep("bad5_9",    p1_tt ^ 16'h0220, 16'hFFFF, p1_tt, 1'b0);
        sweep("mask0",     p1_tt,            16'h0000, p1_tt, 1'b0);
        sweep("allbad",    ~p1_tt,           16'hFFFF, p1_tt, 1'b0);
        sweep("allbad_m",  ~p1_tt,           16'hFFF0, p1_tt, 1'b0);
        sweep("spam",      p1_tt ^ 16'h8001, 16'hFFFF, p1_tt, 1'b1);

        // Abort a sweep 20 cycles in; rst and start together must stay idle.
        dev_tt   = p1_tt;
        expected = ~p1_tt;
        vec_mask = 16'hFFFF;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (19) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("midrst:err_before", (err_cnt != 5'd0), 1);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check_reset("midrst");
        @(posedge clk); #1;
        check("midrst:busy2", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        check("midrst:no_done", dones, 0);
        sweep("after_rst", p1_tt ^ 16'h0100, 16'hF0FF, p1_tt, 1'b0);

        for (int r = 0; r < 6; r++)
            sweep("rand", 16'($urandom), 16'($urandom), 16'($urandom), r[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
